// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, sampled mid-bit on an
// oversampling tick; each good byte is presented with a one-clock valid pulse.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxen,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] START_CHK = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic          sync_q;
  logic          rxs_q;
  state_t        state_q;
  logic          armed_q;
  logic [SW-1:0] scnt_q;
  logic [SW-1:0] scnt_d;
  logic [2:0]    bcnt_q;
  logic [7:0]    sh_q;
  logic [7:0]    rx_data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          busy_q;

  // Two-flop synchronizer; idle-high reset value keeps the line looking idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  assign scnt_d = scnt_q + SW'(1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (rxen) begin
        case (state_q)
          IDLE: begin
            if (rxs_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= START;
              scnt_q  <= '0;
              armed_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            scnt_q <= scnt_d;
            if (scnt_d == START_CHK) begin
              if (!rxs_q) begin
                state_q <= DATA;
                scnt_q  <= '0;
                bcnt_q  <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          DATA: begin
            scnt_q <= scnt_d;
            if (scnt_d == '0) begin
              sh_q   <= {rxs_q, sh_q[7:1]};
              bcnt_q <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) state_q <= STOP;
            end
          end
          STOP: begin
            scnt_q <= scnt_d;
            if (scnt_d == '0) begin
              // A low stop bit leaves armed clear so a held-low break cannot restart.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              armed_q <= rxs_q;
              if (rxs_q) begin
                rx_data_q <= sh_q;
                valid_q   <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus false-start and mid-frame reset sequences.
module tb_uart_rx;

  logic       clk;
  logic       n_rst;
  logic       rxen;
  logic       rxd;
  logic [7:0] rx_data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int div;
  int n_pass;
  int n_total;
  int nvalid;
  int nferr;
  int noverlap;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rxen      (rxen),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample tick: one clk in every div clks.
  initial begin
    int cnt;
    cnt  = 0;
    rxen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt >= div - 1) cnt = 0;
      else cnt++;
      rxen = (cnt == 0);
    end
  end

  initial begin
    nvalid   = 0;
    nferr    = 0;
    noverlap = 0;
    forever begin
      @(negedge clk);
      if (valid) nvalid++;
      if (frame_err) nferr++;
      if (valid && frame_err) noverlap++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic hold(input logic level, input int nbits);
    rxd = level;
    repeat (nbits * 16 * div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    hold(1'b0, 1);
    for (int i = 0; i < 8; i++) hold(data[i], 1);
    hold(stop, 1);
  endtask

  typedef struct {
    int         div;
    int         pre_bits;
    logic [7:0] data;
    logic       stop;
    int         post_low;
    int         exp_dv;
    int         exp_df;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dv0;
    int df0;
    n_pass  = 0;
    n_total = 0;
    div     = 1;
    rxd     = 1'b1;
    n_rst   = 1'b0;

    vecs[0] = '{1, 2, 8'hA5, 1'b1, 0,  1, 0, 8'hA5};
    vecs[1] = '{1, 0, 8'h00, 1'b1, 0,  1, 0, 8'h00};
    vecs[2] = '{1, 0, 8'hFF, 1'b1, 0,  1, 0, 8'hFF};
    vecs[3] = '{1, 0, 8'h3C, 1'b1, 0,  1, 0, 8'h3C};
    vecs[4] = '{1, 2, 8'h55, 1'b0, 20, 0, 1, 8'h3C};
    vecs[5] = '{1, 2, 8'h42, 1'b1, 0,  1, 0, 8'h42};
    vecs[6] = '{3, 2, 8'h96, 1'b1, 0,  1, 0, 8'h96};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      div = vecs[i].div;
      hold(1'b1, vecs[i].pre_bits);
      dv0 = nvalid;
      df0 = nferr;
      send_frame(vecs[i].data, vecs[i].stop);
      hold(1'b0, vecs[i].post_low);
      chk($sformatf("vec%0d_valid_cnt", i), nvalid - dv0, vecs[i].exp_dv);
      chk($sformatf("vec%0d_ferr_cnt", i), nferr - df0, vecs[i].exp_df);
      chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // False start: 4 low clks, rejected at the tick-7 start check.
    div = 1;
    hold(1'b1, 2);
    dv0 = nvalid;
    df0 = nferr;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    chk("fs_busy_high", int'(busy), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("fs_busy_low", int'(busy), 0);
    chk("fs_no_valid", nvalid - dv0, 0);
    chk("fs_no_ferr", nferr - df0, 0);
    hold(1'b1, 2);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 1);
    chk("fs_next_valid_cnt", nvalid - dv0, 1);
    chk("fs_next_rx_data", int'(rx_data), 'h81);
    chk("fs_next_ferr_cnt", nferr - df0, 0);

    // Reset during bit 4 of 0xF0 at 1-in-3 ticks; remaining bits stay high.
    div = 3;
    hold(1'b1, 2);
    dv0 = nvalid;
    df0 = nferr;
    hold(1'b0, 5);
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_busy_before", int'(busy), 1);
    n_rst = 1'b0;
    #2;
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    hold(1'b1, 6);
    chk("rst_no_valid", nvalid - dv0, 0);
    chk("rst_no_ferr", nferr - df0, 0);
    chk("rst_rx_data_after", int'(rx_data), 0);
    chk("rst_busy_after", int'(busy), 0);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 1);
    chk("rec_valid_cnt", nvalid - dv0, 1);
    chk("rec_rx_data", int'(rx_data), 'h3C);

    chk("valid_ferr_overlap", noverlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
